ub_stream_fifo: RTL and testbench

- Sits directly downstream of the unified buffer read port. Buffers its two staggered 16-bit lanes toward the systolic array's left-edge inputs.
- One independent FIFO per lane. Both lanes pop in the same cycles, so the one-cycle lane stagger emitted by the buffer is preserved through stalls.
- The unified buffer has no backpressure, so this block exposes an almost-full hold flag for the sequencer and a sticky overflow flag for debug.

---
 rtl/tpu_pkg.sv | 11 +
 rtl/ub_lane_fifo.sv | 101 ++++++++++
 rtl/ub_stream_fifo.sv | 83 ++++++++
 tb/tb_ub_stream_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared constants and helpers for the unified-buffer stream path
package tpu_pkg;

    localparam int UB_DATA_WIDTH = 16;

    // Width needed to hold an occupancy value from 0 up to and including depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ub_lane_fifo.sv
// rtl/ub_lane_fifo.sv - single-lane registered-output FIFO with sticky overflow
module ub_lane_fifo
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = UB_DATA_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int HOLD_LEVEL = 6
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 push,
    input  logic [DATA_WIDTH-1:0]                push_data,
    input  logic                                 stall,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic                                 out_valid,
    output logic [count_width(FIFO_DEPTH)-1:0]   count,
    output logic                                 overflow,
    output logic                                 almost_full
);

    localparam int CW = count_width(FIFO_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;
    logic                  active;
    logic                  full;
    logic                  pop;
    logic                  push_acc;
    logic                  drop;

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Decide push/pop for this edge; a full lane still accepts when it also pops.
    always_comb begin
        active     = !rst && !flush;
        full       = (count_q == CW'(FIFO_DEPTH));
        pop        = active && !stall && (count_q != '0);
        push_acc   = active && push && (!full || pop);
        drop       = active && push && full && !pop;
        count_next = count_q;
        if (!active) begin
            count_next = '0;
        end else if (push_acc && !pop) begin
            count_next = count_q + 1'b1;
        end else if (pop && !push_acc) begin
            count_next = count_q - 1'b1;
        end
        almost_full = (int'(count_next) >= HOLD_LEVEL);
    end

    // Storage array; contents are never cleared, only the pointers are.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy, output register and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                out_data  <= mem[rd_ptr];
                out_valid <= 1'b1;
                rd_ptr    <= ptr_inc(rd_ptr);
            end else if (!stall) begin
                out_valid <= 1'b0;
            end
            count_q <= count_next;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ub_stream_fifo.sv
// rtl/ub_stream_fifo.sv - two-lane stagger-preserving FIFO between unified buffer and systolic array
module ub_stream_fifo
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH    = UB_DATA_WIDTH,
    parameter int FIFO_DEPTH    = 8,
    parameter int HOLD_HEADROOM = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_WIDTH-1:0]                fifo_data_1_in,
    input  logic [DATA_WIDTH-1:0]                fifo_data_2_in,
    input  logic                                 fifo_valid_1_in,
    input  logic                                 fifo_valid_2_in,
    input  logic                                 fifo_stall_in,
    input  logic                                 fifo_flush_in,
    output logic [DATA_WIDTH-1:0]                fifo_data_1_out,
    output logic [DATA_WIDTH-1:0]                fifo_data_2_out,
    output logic                                 fifo_valid_1_out,
    output logic                                 fifo_valid_2_out,
    output logic                                 fifo_hold_out,
    output logic                                 fifo_overflow_out,
    output logic [count_width(FIFO_DEPTH)-1:0]   fifo_count_1_out,
    output logic [count_width(FIFO_DEPTH)-1:0]   fifo_count_2_out
);

    localparam int HOLD_LEVEL = FIFO_DEPTH - HOLD_HEADROOM;

    logic almost_full_1;
    logic almost_full_2;
    logic overflow_1;
    logic overflow_2;
    logic hold_q;

    ub_lane_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .HOLD_LEVEL (HOLD_LEVEL)
    ) u_lane_1 (
        .clk         (clk),
        .rst         (rst),
        .flush       (fifo_flush_in),
        .push        (fifo_valid_1_in),
        .push_data   (fifo_data_1_in),
        .stall       (fifo_stall_in),
        .out_data    (fifo_data_1_out),
        .out_valid   (fifo_valid_1_out),
        .count       (fifo_count_1_out),
        .overflow    (overflow_1),
        .almost_full (almost_full_1)
    );

    ub_lane_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .HOLD_LEVEL (HOLD_LEVEL)
    ) u_lane_2 (
        .clk         (clk),
        .rst         (rst),
        .flush       (fifo_flush_in),
        .push        (fifo_valid_2_in),
        .push_data   (fifo_data_2_in),
        .stall       (fifo_stall_in),
        .out_data    (fifo_data_2_out),
        .out_valid   (fifo_valid_2_out),
        .count       (fifo_count_2_out),
        .overflow    (overflow_2),
        .almost_full (almost_full_2)
    );

    // Hold is registered from next-cycle occupancy so the sequencer sees it on time.
    always_ff @(posedge clk) begin
        if (rst || fifo_flush_in) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= almost_full_1 || almost_full_2;
        end
    end

    assign fifo_hold_out     = hold_q;
    assign fifo_overflow_out = overflow_1 || overflow_2;

endmodule

// File: tb/tb_ub_stream_fifo.sv
// tb/tb_ub_stream_fifo.sv - directed table-driven bench for ub_stream_fifo
module tb_ub_stream_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d1_in, d2_in;
    logic        v1_in, v2_in, stall, flush;
    logic [15:0] d1_out, d2_out;
    logic        v1_out, v2_out, hold, ovf;
    logic [3:0]  c1, c2;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        v1;
        logic [15:0] d1;
        logic        v2;
        logic [15:0] d2;
        logic        st;
        logic        fl;
        logic [15:0] e_d1;
        logic        e_v1;
        logic [15:0] e_d2;
        logic        e_v2;
        logic [3:0]  e_c1;
        logic [3:0]  e_c2;
        logic        e_hold;
        logic        e_ovf;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    ub_stream_fifo dut (
        .clk               (clk),
        .rst               (rst),
        .fifo_data_1_in    (d1_in),
        .fifo_data_2_in    (d2_in),
        .fifo_valid_1_in   (v1_in),
        .fifo_valid_2_in   (v2_in),
        .fifo_stall_in     (stall),
        .fifo_flush_in     (flush),
        .fifo_data_1_out   (d1_out),
        .fifo_data_2_out   (d2_out),
        .fifo_valid_1_out  (v1_out),
        .fifo_valid_2_out  (v2_out),
        .fifo_hold_out     (hold),
        .fifo_overflow_out (ovf),
        .fifo_count_1_out  (c1),
        .fifo_count_2_out  (c2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [15:0] e_d1, input logic e_v1,
                           input logic [15:0] e_d2, input logic e_v2,
                           input logic [3:0] e_c1, input logic [3:0] e_c2,
                           input logic e_hold, input logic e_ovf);
        chk({tag, ".d1"},   32'(d1_out), 32'(e_d1));
        chk({tag, ".v1"},   32'(v1_out), 32'(e_v1));
        chk({tag, ".d2"},   32'(d2_out), 32'(e_d2));
        chk({tag, ".v2"},   32'(v2_out), 32'(e_v2));
        chk({tag, ".c1"},   32'(c1),     32'(e_c1));
        chk({tag, ".c2"},   32'(c2),     32'(e_c2));
        chk({tag, ".hold"}, 32'(hold),   32'(e_hold));
        chk({tag, ".ovf"},  32'(ovf),    32'(e_ovf));
    endtask

    task automatic drive(input logic a_v1, input logic [15:0] a_d1,
                         input logic a_v2, input logic [15:0] a_d2,
                         input logic a_st, input logic a_fl);
        v1_in = a_v1; d1_in = a_d1;
        v2_in = a_v2; d2_in = a_d2;
        stall = a_st; flush = a_fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Staggered burst: lane1 leads lane2 by one cycle, both at input and output.
        vecs[0]  = '{1, 16'd10, 0, 16'd0,  0, 0,  16'd0,  0, 16'd0,  0, 4'd1, 4'd0, 0, 0};
        vecs[1]  = '{1, 16'd30, 1, 16'd20, 0, 0,  16'd10, 1, 16'd0,  0, 4'd1, 4'd1, 0, 0};
        vecs[2]  = '{0, 16'd0,  1, 16'd40, 0, 0,  16'd30, 1, 16'd20, 1, 4'd0, 4'd1, 0, 0};
        vecs[3]  = '{0, 16'd0,  0, 16'd0,  0, 0,  16'd30, 0, 16'd40, 1, 4'd0, 4'd0, 0, 0};
        vecs[4]  = '{0, 16'd0,  0, 16'd0,  0, 0,  16'd30, 0, 16'd40, 0, 4'd0, 4'd0, 0, 0};
        // Stall hold: 1 on the output, stalled four cycles, then 2 and 3 drain.
        vecs[5]  = '{1, 16'd1,  0, 16'd0,  0, 0,  16'd30, 0, 16'd40, 0, 4'd1, 4'd0, 0, 0};
        vecs[6]  = '{1, 16'd2,  0, 16'd0,  0, 0,  16'd1,  1, 16'd40, 0, 4'd1, 4'd0, 0, 0};
        vecs[7]  = '{1, 16'd3,  0, 16'd0,  1, 0,  16'd1,  1, 16'd40, 0, 4'd2, 4'd0, 0, 0};
        vecs[8]  = '{0, 16'd0,  0, 16'd0,  1, 0,  16'd1,  1, 16'd40, 0, 4'd2, 4'd0, 0, 0};
        vecs[9]  = '{0, 16'd0,  0, 16'd0,  1, 0,  16'd1,  1, 16'd40, 0, 4'd2, 4'd0, 0, 0};
        vecs[10] = '{0, 16'd0,  0, 16'd0,  1, 0,  16'd1,  1, 16'd40, 0, 4'd2, 4'd0, 0, 0};
        vecs[11] = '{0, 16'd0,  0, 16'd0,  0, 0,  16'd2,  1, 16'd40, 0, 4'd1, 4'd0, 0, 0};
        vecs[12] = '{0, 16'd0,  0, 16'd0,  0, 0,  16'd3,  1, 16'd40, 0, 4'd0, 4'd0, 0, 0};
        vecs[13] = '{0, 16'd0,  0, 16'd0,  0, 0,  16'd3,  0, 16'd40, 0, 4'd0, 4'd0, 0, 0};

        // Reset then idle.
        do_reset();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0, 0, 0);
        end

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v1, vecs[i].d1, vecs[i].v2, vecs[i].d2, vecs[i].st, vecs[i].fl);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_d1, vecs[i].e_v1, vecs[i].e_d2, vecs[i].e_v2,
                    vecs[i].e_c1, vecs[i].e_c2, vecs[i].e_hold, vecs[i].e_ovf);
        end

        // Full and overflow on lane 2 under stall; ninth push is dropped.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(0, 0, 1, 16'(k), 1, 0);
            step();
            chk($sformatf("fill%0d.c2", k), 32'(c2), (k < 8) ? k + 1 : 8);
            chk($sformatf("fill%0d.hold", k), 32'(hold), (k + 1 >= 6) ? 1 : 0);
            chk($sformatf("fill%0d.ovf", k), 32'(ovf), (k == 8) ? 1 : 0);
            chk($sformatf("fill%0d.v2", k), 32'(v2_out), 0);
        end
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            step();
            chk($sformatf("drain%0d.d2", k), 32'(d2_out), k);
            chk($sformatf("drain%0d.v2", k), 32'(v2_out), 1);
            chk($sformatf("drain%0d.c2", k), 32'(c2), 7 - k);
            chk($sformatf("drain%0d.ovf", k), 32'(ovf), 1);
        end
        step();
        chk("drain_end.v2", 32'(v2_out), 0);

        // Full lane with simultaneous push and pop.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 1, 16'h0100 + 16'(k), 1, 0);
            step();
        end
        chk("full.c2", 32'(c2), 8);
        drive(0, 0, 1, 16'hBEEF, 0, 0);
        step();
        chk_all("pushpop", 0, 0, 16'h0100, 1, 0, 8, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            step();
            chk($sformatf("pp%0d.d2", k), 32'(d2_out), (k == 8) ? 32'hBEEF : 32'h0100 + k);
            chk($sformatf("pp%0d.c2", k), 32'(c2), 8 - k);
        end
        chk("pp.ovf", 32'(ovf), 0);

        // Flush mid-stream with a held valid and a same-cycle push.
        do_reset();
        drive(1, 16'h00A0, 1, 16'h00B0, 0, 0);
        step();
        drive(1, 16'h00A1, 1, 16'h00B1, 0, 0);
        step();
        for (int k = 2; k < 7; k++) begin
            drive(1, 16'h00A0 + 16'(k), 1, 16'h00B0 + 16'(k), 1, 0);
            step();
        end
        chk_all("preflush", 16'h00A0, 1, 16'h00B0, 1, 6, 6, 1, 0);
        drive(1, 16'h0077, 1, 16'h0077, 1, 1);
        step();
        chk_all("flush", 16'h00A0, 0, 16'h00B0, 0, 0, 0, 0, 0);
        drive(1, 16'h0042, 1, 16'h0042, 0, 0);
        step();
        chk_all("post1", 16'h00A0, 0, 16'h00B0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk_all("post2", 16'h0042, 1, 16'h0042, 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
